// File: rtl/score_bcd_converter.sv
// score_bcd_converter
// Serial binary-to-BCD converter (shift-and-add-3) for a four-digit score
// display. Inputs above 9999 saturate to 9999 and raise overflow.
// Optional feature: define BCD_BLANK_EN to compile in leading-zero blanking;
// without it the blank port is tied to 4'b0000.
//
// Handshake: start is sampled every cycle and accepted only in IDLE (and not
// while rst is high). Once accepted, busy stays high until the conversion
// finishes; done pulses for one cycle with the new digits already on the
// outputs. Starts seen while busy are dropped, not queued.
module score_bcd_converter #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_thou,
    output logic [3:0]       bcd_hund,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             overflow,
    output logic [3:0]       blank,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [31:0]       BCD_MAX  = 32'd9999;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [15:0]        scratch_q, scratch_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [15:0]        digits_q, digits_d;
    logic               ovf_out_q, ovf_out_d;
    logic               load_out;

    logic [15:0]        adj;
    logic               bin_ovf;
    logic [BIN_W-1:0]   bin_clamped;

    // Saturate the captured value so the 16-bit scratch never exceeds four digits.
    always_comb begin
        bin_ovf     = ({{(32 - BIN_W){1'b0}}, bin} > BCD_MAX);
        bin_clamped = bin_ovf ? BCD_MAX[BIN_W-1:0] : bin;
    end

    // Add-3 correction on every BCD nibble that is 5 or more before the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath control: capture in IDLE, shift BIN_W times, publish on entry to DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        ovf_out_d  = ovf_out_q;
        load_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    sr_d       = bin_clamped;
                    scratch_d  = 16'd0;
                    cnt_d      = '0;
                    ovf_pend_d = bin_ovf;
                end
            end
            SHIFT: begin
                scratch_d = {adj[14:0], sr_q[BIN_W-1]};
                sr_d      = {sr_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Outputs are loaded with the final shifted value so they are
                    // already valid during the DONE cycle that carries the pulse.
                    state_d   = DONE;
                    digits_d  = scratch_d;
                    ovf_out_d = ovf_pend_q;
                    load_out  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, scratch and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            scratch_q  <= 16'd0;
            ovf_pend_q <= 1'b0;
            digits_q   <= 16'd0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            scratch_q  <= scratch_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

`ifdef BCD_BLANK_EN
    logic [3:0] blank_q, blank_d;

    // Blank a digit when it and every more-significant digit are zero; ones always shows.
    always_comb begin
        blank_d = blank_q;
        if (load_out) begin
            blank_d[3] = (digits_d[15:12] == 4'd0);
            blank_d[2] = blank_d[3] && (digits_d[11:8] == 4'd0);
            blank_d[1] = blank_d[2] && (digits_d[7:4] == 4'd0);
            blank_d[0] = 1'b0;
        end
    end

    // Blank mask register, updated together with the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= 4'b0000;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    logic unused_load;
    assign unused_load = load_out;
    assign blank       = 4'b0000;
`endif

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign bcd_thou    = digits_q[15:12];
    assign bcd_hund    = digits_q[11:8];
    assign bcd_tens    = digits_q[7:4];
    assign bcd_ones    = digits_q[3:0];
    assign overflow    = ovf_out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Testbench for score_bcd_converter (default BIN_W = 14).
// Define BCD_BLANK_EN for both files to check the blanking variant.
module tb_score_bcd_converter;
    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;
    localparam int W     = 21;

    logic             clk;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_thou, bcd_hund, bcd_tens, bcd_ones;
    logic             overflow;
    logic [3:0]       blank;
    logic [1:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;
    int cyc;
    int done_cnt;
    int done_cyc;

    score_bcd_converter #(.BIN_W(BIN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .bcd_thou   (bcd_thou),
        .bcd_hund   (bcd_hund),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .overflow   (overflow),
        .blank      (blank),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: {overflow, blank, thou, hund, tens, ones}
    function automatic logic [W-1:0] model(input int v);
        int c;
        logic [3:0] th, hu, te, on;
        logic [3:0] bl;
        logic ov;
        ov = (v > 9999);
        c  = ov ? 9999 : v;
        th = 4'(c / 1000);
        hu = 4'((c / 100) % 10);
        te = 4'((c / 10) % 10);
        on = 4'(c % 10);
        bl = 4'b0000;
`ifdef BCD_BLANK_EN
        if (c < 1000) bl[3] = 1'b1;
        if (c < 100)  bl[2] = 1'b1;
        if (c < 10)   bl[1] = 1'b1;
`endif
        return {ov, bl, th, hu, te, on};
    endfunction

    function automatic logic [W-1:0] observed();
        return {overflow, blank, bcd_thou, bcd_hund, bcd_tens, bcd_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t cyc=%0d)", tag, obs, exp, $time, cyc);
        end
    endtask

    // One clock; on a done pulse pop the scoreboard and compare the outputs.
    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(observed()), 32'(e));
            end
        end
    endtask

    task automatic flush_queue(input string tag);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Drive one conversion, check busy/done timing every cycle, and that the
    // result holds in the cycle after done. glitch_cyc > 0 raises start (with
    // bin=8888) for that one cycle, which must be ignored.
    task automatic convert(input int v, input int glitch_cyc, input string tag);
        logic [W-1:0] e;
        e = model(v);
        exp_q.push_back(e);
        bin   = BIN_W'(v);
        start = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            if (i == 1) begin
                start = 1'b0;
                bin   = BIN_W'($urandom_range(0, 16383));
            end
            if (glitch_cyc > 0 && i == glitch_cyc) begin
                start = 1'b1;
                bin   = BIN_W'(8888);
            end else if (i > 1) begin
                start = 1'b0;
            end
            check({tag, "_busy"}, 32'(busy), 32'(i <= LAT));
            check({tag, "_done"}, 32'(done), 32'(i == LAT));
        end
        start = 1'b0;
        check({tag, "_hold"}, 32'(observed()), 32'(e));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(LAT));
        flush_queue(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;

        // reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outputs", 32'(observed()), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // main function and boundaries
        convert(1234, 0, "bin1234");
        convert(0, 0, "bin0");
        convert(40, 0, "bin40");
        convert(9999, 0, "bin9999");
        convert(16383, 0, "bin16383");
        convert(5, 0, "bin5");
        convert(10000, 0, "bin10000");
        convert(1000, 0, "bin1000");
        for (int k = 0; k < 4; k++) begin
            convert(int'($urandom_range(0, 16383)), 0, "random");
        end

        // start while busy (mid-shift and in the DONE cycle) is ignored
        convert(77, 5, "ignore_mid");
        convert(321, LAT, "ignore_done");

        // reset aborts a conversion in progress
        convert(4321, 0, "pre_abort");
        bin   = BIN_W'(1111);
        start = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            check("abort_busy_before", 32'(busy), 32'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_outputs", 32'(observed()), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_outputs_later", 32'(observed()), 32'd0);

        // rst and start together: rst wins
        rst   = 1'b1;
        start = 1'b1;
        bin   = BIN_W'(42);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy), 32'd0);
        check("rst_start_outputs", 32'(observed()), 32'd0);

        // start held high: back-to-back conversions every BIN_W+2 cycles
        exp_q.push_back(model(2500));
        exp_q.push_back(model(2500));
        exp_q.push_back(model(2500));
        bin   = BIN_W'(2500);
        start = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("b2b_done", 32'(done), 32'(cyc == LAT || cyc == 2 * LAT + 1));
        end
        start = 1'b0;
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        for (int i = 0; i < 3 * (LAT + 1) && exp_q.size() > 0; i++) begin
            tick();
            check("b2b_tail_done", 32'(done), 32'(cyc == 3 * LAT + 2));
        end
        check("b2b_tail_count", 32'(done_cnt), 32'd3);
        flush_queue("b2b");
        tick();
        check("b2b_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
